// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU issue arbiter: FSM states, requester ids,
// opcode modifier bit positions and flag width.
package fpu_ctrl_pkg;

  localparam int unsigned FLG_W    = 5;
  localparam int unsigned S_UNSIGN = 22;
  localparam int unsigned S_SIGN   = 23;
  localparam int unsigned V_UNSIGN = 26;
  localparam int unsigned V_SIGN   = 27;

  localparam logic ID_SCALAR = 1'b0;
  localparam logic ID_VECTOR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } fpu_state_e;

  // True when exactly one bit of x is set.
  function automatic logic is_onehot32(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter2.sv
// Two-requester round-robin grant; a simultaneous request goes to whoever
// was not granted last.
module fpu_rr_arbiter2
  import fpu_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_l,
  input  logic i_req_s,
  input  logic i_req_v,
  input  logic i_advance,
  output logic o_gnt_valid_c,
  output logic o_gnt_id_c
);

  logic r_last_grant;

  always_comb begin
    o_gnt_valid_c = i_req_s | i_req_v;
    o_gnt_id_c    = ID_SCALAR;
    if (i_req_s && i_req_v) begin
      o_gnt_id_c = ~r_last_grant;
    end else if (i_req_v) begin
      o_gnt_id_c = ID_VECTOR;
    end
  end

  // Reset to vector so the scalar pipe wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_last_grant <= ID_VECTOR;
    end else if (i_advance) begin
      r_last_grant <= o_gnt_id_c;
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one single-cycle FPU between the scalar pipe and the vector lane:
// arbitrate, register the request, pulse the FPU for one cycle, capture and respond.
module fpu_issue_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned STD   = 31,
  parameter int unsigned SOP_W = 24,
  parameter int unsigned VOP_W = 28
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               s_req_valid,
  output logic               s_req_ready,
  input  logic [SOP_W-1:0]   s_req_op,
  input  logic [127:0]       s_req_opnd,
  input  logic [2:0]         s_req_frm,
  input  logic               v_req_valid,
  output logic               v_req_ready,
  input  logic [VOP_W-1:0]   v_req_op,
  input  logic [127:0]       v_req_opnd,
  input  logic [2:0]         v_req_frm,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [STD:0]       resp_fp,
  output logic [31:0]        resp_rd,
  output logic [FLG_W-1:0]   resp_flags,
  output logic               resp_exc,
  output logic               resp_illegal,
  output logic [STD:0]       fpu_a,
  output logic [STD:0]       fpu_b,
  output logic [STD:0]       fpu_c,
  output logic [31:0]        fpu_int,
  output logic [2:0]         fpu_frm,
  output logic [SOP_W-1:0]   fpu_sfpu_op,
  output logic [VOP_W-1:0]   fpu_vfpu_op,
  output logic [2:0]         fpu_sel,
  input  logic [STD:0]       fpu_resultant,
  input  logic [31:0]        fpu_result_rd,
  input  logic [FLG_W-1:0]   fpu_s_flags,
  input  logic               fpu_exception,
  input  logic               fflags_wr_en,
  input  logic [FLG_W-1:0]   fflags_wr_data,
  output logic [FLG_W-1:0]   fflags,
  output logic               busy
);

  fpu_state_e        r_state;
  logic              r_id;
  logic [STD:0]      r_a, r_b, r_c;
  logic [31:0]       r_int;
  logic [2:0]        r_frm;
  logic [SOP_W-1:0]  r_sop;
  logic [VOP_W-1:0]  r_vop;
  logic              r_resp_valid, r_resp_id, r_resp_exc, r_resp_illegal;
  logic [STD:0]      r_resp_fp;
  logic [31:0]       r_resp_rd;
  logic [FLG_W-1:0]  r_resp_flags;
  logic [FLG_W-1:0]  r_fflags;
  logic              r_busy;

  logic              w_gnt_valid, w_gnt_id, w_idle, w_hs, w_legal;
  logic [SOP_W-1:0]  w_s_core;
  logic [VOP_W-1:0]  w_v_core;
  logic [127:0]      w_opnd;
  logic [2:0]        w_frm;

  fpu_rr_arbiter2 u_arb (
    .clk           (clk),
    .rst_l         (rst_l),
    .i_req_s       (s_req_valid),
    .i_req_v       (v_req_valid),
    .i_advance     (w_hs),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_id_c    (w_gnt_id)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign s_req_ready = w_idle & w_gnt_valid & (w_gnt_id == ID_SCALAR);
  assign v_req_ready = w_idle & w_gnt_valid & (w_gnt_id == ID_VECTOR);
  assign w_hs        = s_req_ready | v_req_ready;

  // Legality ignores the signed/unsigned modifiers; the remaining opcode must be one-hot.
  always_comb begin
    w_s_core           = s_req_op;
    w_s_core[S_UNSIGN] = 1'b0;
    w_s_core[S_SIGN]   = 1'b0;
    w_v_core           = v_req_op;
    w_v_core[V_UNSIGN] = 1'b0;
    w_v_core[V_SIGN]   = 1'b0;
    w_legal = (w_gnt_id == ID_VECTOR) ? is_onehot32(32'(w_v_core))
                                      : is_onehot32(32'(w_s_core));
    w_opnd  = (w_gnt_id == ID_VECTOR) ? v_req_opnd : s_req_opnd;
    w_frm   = (w_gnt_id == ID_VECTOR) ? v_req_frm  : s_req_frm;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state        <= ST_IDLE;
      r_id           <= ID_SCALAR;
      r_a            <= '0;
      r_b            <= '0;
      r_c            <= '0;
      r_int          <= '0;
      r_frm          <= '0;
      r_sop          <= '0;
      r_vop          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= 1'b0;
      r_resp_fp      <= '0;
      r_resp_rd      <= '0;
      r_resp_flags   <= '0;
      r_resp_exc     <= 1'b0;
      r_resp_illegal <= 1'b0;
      r_fflags       <= '0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_id   <= w_gnt_id;
            r_a    <= w_opnd[STD:0];
            r_b    <= w_opnd[32+STD:32];
            r_c    <= w_opnd[64+STD:64];
            r_int  <= w_opnd[127:96];
            r_frm  <= w_frm;
            r_busy <= 1'b1;
            if (w_legal) begin
              r_sop   <= (w_gnt_id == ID_SCALAR) ? s_req_op : '0;
              r_vop   <= (w_gnt_id == ID_VECTOR) ? v_req_op : '0;
              r_state <= ST_EXEC;
            end else begin
              r_resp_valid   <= 1'b1;
              r_resp_id      <= w_gnt_id;
              r_resp_fp      <= '0;
              r_resp_rd      <= '0;
              r_resp_flags   <= '0;
              r_resp_exc     <= 1'b0;
              r_resp_illegal <= 1'b1;
              r_state        <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          r_sop   <= '0;
          r_vop   <= '0;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_resp_valid   <= 1'b1;
          r_resp_id      <= r_id;
          r_resp_fp      <= fpu_resultant;
          r_resp_rd      <= fpu_result_rd;
          r_resp_flags   <= fpu_s_flags;
          r_resp_exc     <= fpu_exception;
          r_resp_illegal <= 1'b0;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A CSR write landing in the capture cycle still keeps the captured flags.
      if (r_state == ST_CAPT) begin
        r_fflags <= (fflags_wr_en ? fflags_wr_data : r_fflags) | fpu_s_flags;
      end else if (fflags_wr_en) begin
        r_fflags <= fflags_wr_data;
      end
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_fp      = r_resp_fp;
  assign resp_rd      = r_resp_rd;
  assign resp_flags   = r_resp_flags;
  assign resp_exc     = r_resp_exc;
  assign resp_illegal = r_resp_illegal;
  assign fpu_a        = r_a;
  assign fpu_b        = r_b;
  assign fpu_c        = r_c;
  assign fpu_int      = r_int;
  assign fpu_frm      = r_frm;
  assign fpu_sfpu_op  = r_sop;
  assign fpu_vfpu_op  = r_vop;
  assign fpu_sel      = 3'b000;
  assign fflags       = r_fflags;
  assign busy         = r_busy;

endmodule
